// File: rtl/input_debouncer.sv
// Input conditioning: two-flop synchronizer plus a 4-state Moore debounce FSM.
// Produces a clean level w with one-cycle rise/fall strobes and a busy flag.
module input_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic Clock,
  input  logic Reset,
  input  logic w_raw,
  output logic w,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    CHECK_HIGH  = 2'd1,
    STABLE_HIGH = 2'd2,
    CHECK_LOW   = 2'd3
  } state_e;

  logic             s1_q, s2_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             w_q, w_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             busy_q, busy_d;

  // State, counter, synchronizer and output registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= STABLE_LOW;
      cnt_q   <= '0;
      w_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      s1_q    <= w_raw;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic; outputs decode the next state so they register with it
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    case (state_q)
      STABLE_LOW: begin
        if (s2_q) begin
          state_d = CHECK_HIGH;
          cnt_d   = CNT_W'(1);
        end
      end
      CHECK_HIGH: begin
        if (!s2_q) begin
          state_d = STABLE_LOW;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HIGH;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STABLE_HIGH: begin
        if (!s2_q) begin
          state_d = CHECK_LOW;
          cnt_d   = CNT_W'(1);
        end
      end
      CHECK_LOW: begin
        if (s2_q) begin
          state_d = STABLE_HIGH;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LOW;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = STABLE_LOW;
      end
    endcase

    w_d    = (state_d == STABLE_HIGH) || (state_d == CHECK_LOW);
    busy_d = (state_d == CHECK_HIGH) || (state_d == CHECK_LOW);
  end

  assign w    = w_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer (default DEBOUNCE_CYCLES = 4).
// Outputs are compared as {w, rise, fall, busy} one time unit after each rising edge.
module tb_input_debouncer;

  logic Clock;
  logic Reset;
  logic w_raw;
  logic w, rise, fall, busy;

  int checks;
  int errors;

  input_debouncer #(.DEBOUNCE_CYCLES(4)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .w_raw (w_raw),
    .w     (w),
    .rise  (rise),
    .fall  (fall),
    .busy  (busy)
  );

  initial Clock = 1'b0;
  always #10 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Reset with w_raw high, then release: rise on the 6th edge after release
  task automatic test_reset();
    logic [3:0] exp;
    Reset = 1'b1;
    w_raw = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      tick();
      exp = 4'b0000;
      checks++;
      if ({w, rise, fall, busy} !== exp) begin
        errors++;
        $display("FAIL reset_hold edge%0d: got %b want %b", i, {w, rise, fall, busy}, exp);
      end
    end
    Reset = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      exp = {(i >= 6), (i == 6), 1'b0, (i >= 3 && i <= 5)};
      checks++;
      if ({w, rise, fall, busy} !== exp) begin
        errors++;
        $display("FAIL reset_release edge%0d: got %b want %b", i, {w, rise, fall, busy}, exp);
      end
    end
  endtask

  // From stable high, w_raw falls and holds: fall on edge 6
  task automatic test_clean_fall();
    logic [3:0] exp;
    w_raw = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      exp = {(i < 6), 1'b0, (i == 6), (i >= 3 && i <= 5)};
      checks++;
      if ({w, rise, fall, busy} !== exp) begin
        errors++;
        $display("FAIL clean_fall edge%0d: got %b want %b", i, {w, rise, fall, busy}, exp);
      end
    end
  endtask

  // From stable low, w_raw rises and holds: rise on edge 6
  task automatic test_clean_rise();
    logic [3:0] exp;
    w_raw = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp = {(i >= 6), (i == 6), 1'b0, (i >= 3 && i <= 5)};
      checks++;
      if ({w, rise, fall, busy} !== exp) begin
        errors++;
        $display("FAIL clean_rise edge%0d: got %b want %b", i, {w, rise, fall, busy}, exp);
      end
    end
  endtask

  // Three high cycles only: busy pulses, the low sample on the last count rejects
  task automatic test_glitch_reject();
    logic [3:0] exp;
    w_raw = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (i == 3) w_raw = 1'b0;
      exp = {1'b0, 1'b0, 1'b0, (i >= 3 && i <= 5)};
      checks++;
      if ({w, rise, fall, busy} !== exp) begin
        errors++;
        $display("FAIL glitch_reject edge%0d: got %b want %b", i, {w, rise, fall, busy}, exp);
      end
    end
  endtask

  // High 3, low 1, then high held: first burst rejected, rise 6 edges after final rise
  task automatic test_last_sample_bounce();
    logic [3:0] exp;
    w_raw = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 3) w_raw = 1'b0;
      if (i == 4) w_raw = 1'b1;
      exp = {(i >= 10), (i == 10), 1'b0,
             ((i >= 3 && i <= 5) || (i >= 7 && i <= 9))};
      checks++;
      if ({w, rise, fall, busy} !== exp) begin
        errors++;
        $display("FAIL last_sample_bounce edge%0d: got %b want %b", i, {w, rise, fall, busy}, exp);
      end
    end
  endtask

  // Reset while in CHECK_HIGH clears everything; full rise restarts after release
  task automatic test_reset_mid_check();
    logic [3:0] exp;
    w_raw = 1'b1;
    for (int i = 1; i <= 3; i++) tick();
    exp = 4'b0001;
    checks++;
    if ({w, rise, fall, busy} !== exp) begin
      errors++;
      $display("FAIL mid_check_busy: got %b want %b", {w, rise, fall, busy}, exp);
    end
    Reset = 1'b1;
    tick();
    exp = 4'b0000;
    checks++;
    if ({w, rise, fall, busy} !== exp) begin
      errors++;
      $display("FAIL mid_check_reset: got %b want %b", {w, rise, fall, busy}, exp);
    end
    Reset = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      exp = {(i >= 6), (i == 6), 1'b0, (i >= 3 && i <= 5)};
      checks++;
      if ({w, rise, fall, busy} !== exp) begin
        errors++;
        $display("FAIL mid_check_restart edge%0d: got %b want %b", i, {w, rise, fall, busy}, exp);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Reset  = 1'b1;
    w_raw  = 1'b0;
    test_reset();
    test_clean_fall();
    test_clean_rise();
    test_clean_fall();
    test_glitch_reject();
    test_last_sample_bounce();
    test_clean_fall();
    test_reset_mid_check();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
